datamem_arbiter: RTL and testbench
==================================

// Module: datamem_arbiter
// PURPOSE
//  Two-port arbiter and sequencer for the single-ported data memory (sync write, async read).
//  Requester 0 is the CPU load/store path; requester 1 is the secondary master (debug/DMA).
//  Grants one transaction at a time with round-robin fairness.
//  Drives the memory write enable, address and write data; returns read data via a response handshake.
// PARAMETERS
//  WIDTH      32  data and address width of request/response buses
//  ADDR_BITS  5   memory index bits taken from addr[ADDR_BITS-1:0]
// PORTS
//  clk          in   1          rising-edge clock
//  rst          in   1          asynchronous, active-high reset
//  req_valid    in   2          per-requester request valid; bit i = requester i
//  req_ready    out  2          per-requester request accepted (combinational)
//  req_we       in   2          1 = store, 0 = load
//  req_addr0/1  in   WIDTH      byte-free word index from requester 0/1
//  req_wdata0/1 in   WIDTH      store data from requester 0/1
//  rsp_valid    out  2          response valid, bit i = requester i
//  rsp_ready    in   2          requester i accepts its response
//  rsp_rdata    out  WIDTH      load data (0 for stores)
//  mem_we       out  1          memory write enable
//  mem_addr     out  ADDR_BITS  memory index
//  mem_wdata    out  WIDTH      memory write data
//  mem_rdata    in   WIDTH      memory async read data
// BEHAVIOUR
//  FSM states: IDLE, ACCESS, RESP.
//  Reset (async, immediate):
//   - state = IDLE, last_grant = 1 (requester 0 wins first), rsp_valid = 0
//   - mem_we = 0, rsp_rdata = 0, captured addr/wdata/we = 0
//  IDLE:
//   - if any req_valid, pick the winner: sole requester, or on a tie the one != last_grant
//   - req_ready[winner] = 1 in this cycle only (never both bits)
//   - capture winner id, we, addr[ADDR_BITS-1:0], wdata; go to ACCESS; last_grant <= winner
//   - if no req_valid, stay in IDLE
//  ACCESS (exactly 1 cycle):
//   - mem_addr/mem_wdata drive captured values
//   - mem_we = captured we (only asserted in ACCESS) -> memory writes on the next rising edge
//   - rsp_rdata <= we ? 0 : mem_rdata; go to RESP
//  RESP:
//   - rsp_valid[winner] = 1, held with rsp_rdata stable until rsp_ready[winner] = 1
//   - on that handshake edge go to IDLE; no new grant in the same cycle
//  Throughput: a transaction occupies 3 cycles minimum.
//   - request accepted in cycle N; response visible from cycle N+2
//  Outside ACCESS: mem_we = 0; mem_addr/mem_wdata hold captured values.
//  req_ready = 0 in ACCESS and RESP; requesters hold valid and payload until ready.
//  rsp_ready of the non-winner is ignored.
//  rst asserted mid-transaction:
//   - abort to IDLE, drop the pending response
//   - a write in ACCESS whose edge coincides with rst is not guaranteed; mem_we drops immediately
//  last_grant changes only on acceptance, so a lone requester may win repeatedly.
// TESTING
//  1. Store via requester 0: addr=3, wdata=0xDEADBEEF
//     -> mem_we high for exactly 1 cycle with mem_addr=3; rsp_valid[0] at N+2; rsp_rdata=0.
//  2. Load via requester 1: addr=3, memory holding 0xDEADBEEF
//     -> rsp_valid[1] at N+2 with rsp_rdata=0xDEADBEEF; rsp_valid[0] stays 0.
//  3. Both requesters valid continuously after reset
//     -> grants alternate 0,1,0,1 over 4 transactions; req_ready never 2'b11.
//  4. Response backpressure: rsp_ready[0] held 0 for 5 cycles
//     -> rsp_valid/rsp_rdata stable; no new grant; IDLE one cycle after rsp_ready rises.
//  5. addr=0x25 (bit 5 set) -> mem_addr=5 (index truncated to ADDR_BITS).
//  6. rst pulsed during ACCESS of a store
//     -> mem_we and rsp_valid drop immediately; after release, requester 0 wins a tie.

Source files
------------

// File: rtl/datamem_arbiter.sv
// Round-robin arbiter/sequencer granting one of two requesters access to a
// single-ported data memory, one transaction at a time (IDLE -> ACCESS -> RESP).
module datamem_arbiter #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [1:0]           req_we_i,
  input  logic [WIDTH-1:0]     req_addr0_i,
  input  logic [WIDTH-1:0]     req_addr1_i,
  input  logic [WIDTH-1:0]     req_wdata0_i,
  input  logic [WIDTH-1:0]     req_wdata1_i,
  output logic [1:0]           rsp_valid_o,
  input  logic [1:0]           rsp_ready_i,
  output logic [WIDTH-1:0]     rsp_rdata_o,
  output logic                 mem_we_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [WIDTH-1:0]     mem_wdata_o,
  input  logic [WIDTH-1:0]     mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 winner_q, winner_d;
  logic                 we_q, we_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]     wdata_q, wdata_d;
  logic [WIDTH-1:0]     rdata_q, rdata_d;
  logic                 grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // On a tie the requester that did not win last time gets the grant.
  assign grant = (req_valid_i == 2'b11) ? ~last_grant_q : req_valid_i[1];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    req_ready_o  = 2'b00;
    rsp_valid_o  = 2'b00;
    mem_we_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          req_ready_o[grant] = 1'b1;
          winner_d           = grant;
          last_grant_d       = grant;
          we_d               = req_we_i[grant];
          addr_d             = grant ? req_addr1_i[ADDR_BITS-1:0] : req_addr0_i[ADDR_BITS-1:0];
          wdata_d            = grant ? req_wdata1_i : req_wdata0_i;
          state_d            = ACCESS;
        end
      end
      ACCESS: begin
        mem_we_o = we_q;
        rdata_d  = we_q ? '0 : mem_rdata_i;
        state_d  = RESP;
      end
      RESP: begin
        rsp_valid_o[winner_q] = 1'b1;
        if (rsp_ready_i[winner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rsp_rdata_o = rdata_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Randomized bench for datamem_arbiter: a transaction-level model (round-robin
// winner, word array, fixed 3-cycle sequence) predicts grants, memory drive and responses.
module tb_datamem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1, rsp_rdata;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  datamem_arbiter #(.WIDTH(32), .ADDR_BITS(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr0_i(req_addr0), .req_addr1_i(req_addr1),
    .req_wdata0_i(req_wdata0), .req_wdata1_i(req_wdata1),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory the arbiter drives: sync write, async read.
  logic [31:0] mem_arr [32];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem_arr[i] <= 32'h0;
    end else if (mem_we) begin
      mem_arr[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem_arr[mem_addr];

  // Reference model state.
  logic [31:0] ref_mem [32];
  logic        ref_last;
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Runs one transaction starting in an IDLE cycle (called at posedge+1).
  task automatic do_txn(input logic [1:0] v, input logic [1:0] we,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] w0, input logic [31:0] w1,
                        input int delay);
    logic        w;
    logic        t_we;
    logic [4:0]  idx;
    logic [31:0] t_wd, exp_rd;
    req_valid = v; req_we = we; req_addr0 = a0; req_addr1 = a1;
    req_wdata0 = w0; req_wdata1 = w1; rsp_ready = 2'b00;
    if (v == 2'b00) begin
      @(negedge clk);
      check("idle_ready", {30'h0, req_ready}, 32'h0);
      @(posedge clk); #1;
      $display("txn idle cycle");
      return;
    end
    w    = (v == 2'b11) ? ~ref_last : v[1];
    t_we = we[w];
    idx  = w ? a1[4:0] : a0[4:0];
    t_wd = w ? w1 : w0;
    @(negedge clk);
    check("grant", {30'h0, req_ready}, (w ? 32'h2 : 32'h1));
    check("rsp_idle", {30'h0, rsp_valid}, 32'h0);
    check("we_idle", {31'h0, mem_we}, 32'h0);
    @(posedge clk); #1;
    ref_last = w;
    // Noise after acceptance must be ignored until the response completes.
    req_valid = 2'($urandom); req_we = 2'($urandom);
    req_addr0 = $urandom; req_addr1 = $urandom; rsp_ready = 2'($urandom);
    @(negedge clk);
    check("access_we", {31'h0, mem_we}, {31'h0, t_we});
    check("access_addr", {27'h0, mem_addr}, {27'h0, idx});
    if (t_we) check("access_wdata", mem_wdata, t_wd);
    check("access_ready", {30'h0, req_ready}, 32'h0);
    check("access_rsp", {30'h0, rsp_valid}, 32'h0);
    exp_rd = t_we ? 32'h0 : ref_mem[idx];
    if (t_we) ref_mem[idx] = t_wd;
    @(posedge clk); #1;
    for (int c = 0; c <= delay; c++) begin
      rsp_ready = 2'($urandom);
      rsp_ready[w] = (c == delay);
      @(negedge clk);
      check("rsp_valid", {30'h0, rsp_valid}, (w ? 32'h2 : 32'h1));
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("rsp_ready", {30'h0, req_ready}, 32'h0);
      check("rsp_we", {31'h0, mem_we}, 32'h0);
      @(posedge clk); #1;
    end
    req_valid = 2'b00; rsp_ready = 2'b00;
    $display("txn req=%0d we=%0d idx=%0d rdata=0x%08h stall=%0d", w, t_we, idx, exp_rd, delay);
  endtask

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    req_valid = 2'b00; req_we = 2'b00; rsp_ready = 2'b00;
    req_addr0 = 32'h0; req_addr1 = 32'h0; req_wdata0 = 32'h0; req_wdata1 = 32'h0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    ref_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", {30'h0, rsp_valid}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_addr", {27'h0, mem_addr}, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    rst = 1'b0; mem_clr = 1'b0;
    @(posedge clk); #1;

    // Directed: store, load back, alternating ties, backpressure, truncation.
    do_txn(2'b01, 2'b01, 32'd3, 32'd0, 32'hDEADBEEF, 32'h0, 0);
    do_txn(2'b10, 2'b00, 32'd0, 32'd3, 32'h0, 32'h0, 0);
    for (int k = 0; k < 4; k++)
      do_txn(2'b11, 2'b00, 32'($urandom), 32'($urandom), 32'h0, 32'h0, 0);
    do_txn(2'b01, 2'b00, 32'd3, 32'd0, 32'h0, 32'h0, 5);
    do_txn(2'b10, 2'b10, 32'd0, 32'h25, 32'h0, 32'h12345678, 0);
    do_txn(2'b01, 2'b00, 32'd5, 32'd0, 32'h0, 32'h0, 1);

    // Reset during ACCESS of a store: outputs drop at once, no write lands.
    req_valid = 2'b01; req_we = 2'b01; req_addr0 = 32'd7; req_wdata0 = 32'hCAFEF00D;
    @(negedge clk);
    check("pre_rst_grant", {30'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    check("pre_rst_we", {31'h0, mem_we}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("rst_drop_we", {31'h0, mem_we}, 32'h0);
    check("rst_drop_rsp", {30'h0, rsp_valid}, 32'h0);
    @(posedge clk); #1;
    check("rst_hold_rsp", {30'h0, rsp_valid}, 32'h0);
    rst = 1'b0;
    ref_last = 1'b1;
    $display("txn reset during access");
    do_txn(2'b11, 2'b00, 32'd7, 32'd7, 32'h0, 32'h0, 0);

    for (int k = 0; k < 150; k++)
      do_txn(2'($urandom), 2'($urandom), $urandom, $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
